// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan monitor: segment patterns, digit codes, FSM states.
package seg_pkg;

  localparam logic [3:0] DIG_BLANK = 4'hE;
  localparam logic [3:0] DIG_ERR   = 4'hF;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_6_ALT = 7'h7C;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_7_ALT = 7'h27;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_9_ALT = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } scan_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg_scan_monitor_if.sv
// Multiplexed 7-segment scan bus: the display driver is master, the monitor only listens.
interface seg_scan_monitor_if;
  logic [6:0] seg_in;
  logic [3:0] an_in;

  modport master (output seg_in, output an_in);
  modport slave  (input  seg_in, input  an_in);
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-high segment pattern back to a BCD/blank/error code.
module seg7_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = DIG_ERR;
    err  = 1'b0;
    case (pattern)
      SEG_0:                code = 4'd0;
      SEG_1:                code = 4'd1;
      SEG_2:                code = 4'd2;
      SEG_3:                code = 4'd3;
      SEG_4:                code = 4'd4;
      SEG_5:                code = 4'd5;
      SEG_6, SEG_6_ALT:     code = 4'd6;
      SEG_7, SEG_7_ALT:     code = 4'd7;
      SEG_8:                code = 4'd8;
      SEG_9, SEG_9_ALT:     code = 4'd9;
      SEG_BLANK:            code = DIG_BLANK;
      default: begin
        code = DIG_ERR;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_monitor.sv
// Passive 7-segment scan receiver: synchronizes the bus, waits for each slot to settle,
// decodes it and rebuilds the displayed digits and the 2-digit value.
module seg_scan_monitor
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int STALE_CYCLES   = 2_000_000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_monitor_if.slave   bus,
  output logic [15:0]         digit_code,
  output logic [7:0]          value,
  output logic                value_valid,
  output logic                update_pulse,
  output logic                pattern_err,
  output logic [3:0]          stale
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int ST_W  = $clog2(STALE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [ST_W-1:0]  STALE_MAX   = ST_W'(STALE_CYCLES);
  localparam logic [ST_W-1:0]  STALE_LAST  = ST_W'(STALE_CYCLES - 1);

  logic [6:0]  seg_meta, seg_sync, seg_s;
  logic [3:0]  an_meta, an_sync, an_s;
  logic [10:0] bus_prev;
  logic        bus_changed, an_onehot;
  logic [1:0]  sel_idx;
  logic [SET_W-1:0] settle_cnt;
  logic [ST_W-1:0]  stale_cnt [4];
  logic [3:0]  dec_code;
  logic        dec_err;
  logic        capture;
  logic [15:0] digit_code_d;
  logic [3:0]  ones, tens, tens_val;
  logic        valid_now;
  logic [7:0]  value_calc;

  scan_state_t state, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta <= '0;
      seg_sync <= '0;
      an_meta  <= '0;
      an_sync  <= '0;
      bus_prev <= '0;
    end else begin
      seg_meta <= bus.seg_in;
      seg_sync <= seg_meta;
      an_meta  <= bus.an_in;
      an_sync  <= an_meta;
      bus_prev <= {seg_s, an_s};
    end
  end

  assign seg_s       = (SEG_ACTIVE_LOW != 0) ? ~seg_sync : seg_sync;
  assign an_s        = (AN_ACTIVE_LOW != 0) ? ~an_sync : an_sync;
  assign bus_changed = ({seg_s, an_s} != bus_prev);
  assign an_onehot   = is_onehot4(an_s);

  always_comb begin
    sel_idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (an_s[i]) sel_idx = i[1:0];
    end
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_s),
    .code    (dec_code),
    .err     (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (an_onehot) state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (!an_onehot)                      state_next = ST_IDLE;
        else if (!bus_changed && settle_cnt == SETTLE_LAST) state_next = ST_HOLD;
      end
      ST_HOLD:   if (bus_changed) state_next = an_onehot ? ST_SETTLE : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    capture = (state == ST_SETTLE) && an_onehot && !bus_changed && (settle_cnt == SETTLE_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state != ST_SETTLE || bus_changed) begin
      settle_cnt <= '0;
    end else if (settle_cnt != SETTLE_LAST) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // A capture on a digit overrides that digit's stale saturation in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_code  <= {4{DIG_BLANK}};
      stale       <= '1;
      pattern_err <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) stale_cnt[i] <= '0;
    end else begin
      pattern_err <= capture && dec_err;
      for (int unsigned i = 0; i < 4; i++) begin
        if (capture && sel_idx == i[1:0]) begin
          digit_code[4*i +: 4] <= dec_code;
          stale[i]             <= 1'b0;
          stale_cnt[i]         <= '0;
        end else if (stale_cnt[i] != STALE_MAX) begin
          stale_cnt[i] <= stale_cnt[i] + 1'b1;
          if (stale_cnt[i] == STALE_LAST) begin
            stale[i]             <= 1'b1;
            digit_code[4*i +: 4] <= DIG_BLANK;
          end
        end
      end
    end
  end

  assign ones       = digit_code[3:0];
  assign tens       = digit_code[7:4];
  assign tens_val   = (tens == DIG_BLANK) ? 4'd0 : tens;
  assign valid_now  = (ones <= 4'd9) && ((tens <= 4'd9) || (tens == DIG_BLANK));
  assign value_calc = ({4'd0, tens_val} * 8'd10) + {4'd0, ones};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_code_d <= {4{DIG_BLANK}};
      update_pulse <= 1'b0;
      value        <= '0;
      value_valid  <= 1'b0;
    end else begin
      digit_code_d <= digit_code;
      update_pulse <= (digit_code != digit_code_d);
      value_valid  <= valid_now;
      if (valid_now) value <= value_calc;
    end
  end

endmodule
